fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 36 +++
 rtl/fetch_unit.sv | 85 ++++++++
 tb/tb_fetch_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, redirect request and decoder output.
interface fetch_unit_if;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [7:0]  out_pc;
    logic        halted;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output halted
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  halted
    );
endinterface

// File: rtl/fetch_unit.sv
// Single-stage instruction fetch: registered output slot with ready/valid,
// redirect flush and halt-on-opcode.
module fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [3:0] HALT_OPC = 4'hF
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);
    typedef enum logic {RUN, HALTED} state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_instr_q, out_instr_d;
    logic [7:0]  out_pc_q, out_pc_d;
    logic        halted_q, halted_d;
    logic        load_slot;

    assign load_slot = !out_valid_q || bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            halted_q    <= halted_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;

        if (bus.redirect_valid) begin
            // Flush only the valid bit; the stale word/pc may linger.
            pc_d        = bus.redirect_pc;
            out_valid_d = 1'b0;
            state_d     = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (load_slot) begin
                        out_instr_d = bus.imem_data;
                        out_pc_d    = pc_q;
                        out_valid_d = 1'b1;
                        if (bus.imem_data[15:12] == HALT_OPC) begin
                            state_d = HALTED;
                        end else begin
                            pc_d = pc_q + 8'd1;
                        end
                    end
                end
                HALTED: begin
                    if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                    end
                end
                default: state_d = RUN;
            endcase
        end

        // Tracks the next state so halted_q always equals (state_q == HALTED).
        halted_d = (state_d == HALTED);
    end

    assign bus.imem_addr = pc_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_pc    = out_pc_q;
    assign bus.halted    = halted_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall, halt, redirect, wrap, async reset.
module tb_fetch_unit;
    logic clk;
    logic rst_n;
    logic [15:0] mem [256];

    int unsigned checks;
    int unsigned errors;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(8'h00), .HALT_OPC(4'hF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    assign bus.imem_data = mem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [15:0] instr,
                             input logic [7:0] pc);
        check_val({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        if (v) begin
            check_val({tag, ".instr"}, 32'(bus.out_instr), 32'(instr));
            check_val({tag, ".pc"}, 32'(bus.out_pc), 32'(pc));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]     = 16'h1012;
        mem[1]     = 16'h3220;
        mem[2]     = 16'h4230;
        mem[3]     = 16'hF000;
        mem[8'h40] = 16'h7040;
        mem[8'hFE] = 16'h5AFE;
        mem[8'hFF] = 16'h6BFF;

        rst_n              = 1'b0;
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 8'h00;

        #2;
        check_val("rst.valid", 32'(bus.out_valid), 0);
        check_val("rst.halted", 32'(bus.halted), 0);
        check_val("rst.instr", 32'(bus.out_instr), 0);
        check_val("rst.pc", 32'(bus.out_pc), 0);
        check_val("rst.addr", 32'(bus.imem_addr), 0);
        #1 rst_n = 1'b1;

        // Back-to-back fetch of 0..2, then halt word at 3
        tick(); check_out("seq0", 1'b1, 16'h1012, 8'h00);
        tick(); check_out("seq1", 1'b1, 16'h3220, 8'h01);
        tick(); check_out("seq2", 1'b1, 16'h4230, 8'h02);
        tick(); check_out("halt", 1'b1, 16'hF000, 8'h03);
        check_val("halt.halted", 32'(bus.halted), 1);
        check_val("halt.addr", 32'(bus.imem_addr), 3);
        bus.out_ready = 1'b0;
        tick(); check_out("halt.stall", 1'b1, 16'hF000, 8'h03);
        check_val("halt.stall.addr", 32'(bus.imem_addr), 3);
        bus.out_ready = 1'b1;
        tick(); check_out("halt.drain", 1'b0, 16'h0, 8'h0);
        check_val("halt.drain.halted", 32'(bus.halted), 1);
        check_val("halt.drain.addr", 32'(bus.imem_addr), 3);

        // Redirect out of HALTED back to 0
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h00;
        tick(); bus.redirect_valid = 1'b0;
        check_val("unhalt.halted", 32'(bus.halted), 0);
        check_val("unhalt.valid", 32'(bus.out_valid), 0);
        check_val("unhalt.addr", 32'(bus.imem_addr), 0);
        tick(); check_out("re0", 1'b1, 16'h1012, 8'h00);
        tick(); check_out("re1", 1'b1, 16'h3220, 8'h01);

        // Three-cycle stall on 3220
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("stall", 1'b1, 16'h3220, 8'h01);
            check_val("stall.addr", 32'(bus.imem_addr), 2);
        end
        bus.out_ready = 1'b1;
        tick(); check_out("resume", 1'b1, 16'h4230, 8'h02);

        // Redirect to 0x40 while stalled
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h40;
        tick(); bus.redirect_valid = 1'b0;
        check_val("redir.valid", 32'(bus.out_valid), 0);
        check_val("redir.addr", 32'(bus.imem_addr), 8'h40);
        tick(); check_out("redir.first", 1'b1, 16'h7040, 8'h40);

        // PC wrap FE -> FF -> 00
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'hFE;
        tick(); bus.redirect_valid = 1'b0;
        check_val("wrap.bubble", 32'(bus.out_valid), 0);
        tick(); check_out("wrapFE", 1'b1, 16'h5AFE, 8'hFE);
        tick(); check_out("wrapFF", 1'b1, 16'h6BFF, 8'hFF);
        tick(); check_out("wrap00", 1'b1, 16'h1012, 8'h00);
        tick(); check_out("wrap01", 1'b1, 16'h3220, 8'h01);

        // Asynchronous reset between edges while stalled
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_val("arst.valid", 32'(bus.out_valid), 0);
        check_val("arst.halted", 32'(bus.halted), 0);
        check_val("arst.addr", 32'(bus.imem_addr), 0);
        check_val("arst.pc", 32'(bus.out_pc), 0);
        #2 rst_n = 1'b1;
        tick(); check_out("arst.first", 1'b1, 16'h1012, 8'h00);
        check_val("arst.first.addr", 32'(bus.imem_addr), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
